control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Main decoder of the single-cycle RV32I core. Maps the 7-bit instruction opcode to the datapath control strobes: register-file write, data-memory read/write, writeback select, ALU operand select, branch, ALU-op class and immediate format. Outputs are registered on the core clock. An illegal-opcode flag and a jump strobe are also provided.

Parameters:
None.

Ports:
clk  input  1  core clock; all outputs update on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  decode enable. 1 = outputs load the new decode; 0 = outputs hold their value.
opcode  input  7  instruction bits [6:0].
reg_write  output  1  register-file write enable.
mem_write  output  1  data-memory write enable.
mem_read  output  1  data-memory read enable.
mem_to_reg  output  1  writeback select. 1 = memory data; 0 = ALU result.
alu_src  output  1  ALU operand B select. 1 = immediate; 0 = rs2.
branch  output  1  conditional-branch instruction.
jump  output  1  JAL instruction.
alu_op  output  2  ALU class. 00 = add; 01 = subtract/compare; 10 = funct-decoded.
imm_src  output  2  immediate format. 00 = I; 01 = S; 10 = B; 11 = J.
illegal_op  output  1  opcode not in the decode table.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset value: while rst_n = 0, every output is 0. Assertion clears the outputs immediately, without waiting for a clock edge. Deassertion takes effect at the next rising clk edge.
- Latency: on each rising clk edge with en = 1, all outputs take the decode of the opcode sampled at that edge. Latency is one cycle. There is no combinational path from opcode to the outputs.
- Hold: with en = 0, all outputs keep their previous values.
- Decode table. Listed signals are 1; every unlisted 1-bit output is 0.
  - 0110011 (R-type): reg_write. alu_op = 10, imm_src = 00.
  - 0010011 (I-type ALU): reg_write, alu_src. alu_op = 10, imm_src = 00.
  - 0000011 (load): reg_write, mem_read, mem_to_reg, alu_src. alu_op = 00, imm_src = 00.
  - 0100011 (store): mem_write, alu_src. alu_op = 00, imm_src = 01.
  - 1100011 (branch): branch. alu_op = 01, imm_src = 10.
  - 1101111 (JAL): reg_write, jump. alu_op = 00, imm_src = 11.
  - Any other opcode, including X/Z: all strobes 0, alu_op = 00, imm_src = 00, illegal_op = 1. This makes the instruction a safe NOP.
- Invariants, true in every cycle:
  - mem_read and mem_write are never both 1.
  - mem_to_reg = 1 implies mem_read = 1.
  - At most one of {branch, jump, mem_write} is 1.
- Reset mid-operation forces the zero state regardless of en. The first decode after release happens at the first rising edge where rst_n = 1 and en = 1.

Test Plan:
1. Reset: hold rst_n = 0 and apply opcode 0110011 with clock edges -> all outputs 0. Then assert rst_n = 0 asynchronously mid-cycle after a valid decode -> outputs go to 0 immediately, before the next edge.
2. R/I decode: en = 1, opcode 0110011, one edge -> reg_write = 1, alu_op = 10, imm_src = 00, others 0. Then opcode 0010011 -> reg_write = 1, alu_src = 1, alu_op = 10, imm_src = 00, others 0.
3. Memory decode: opcode 0000011 -> reg_write, mem_read, mem_to_reg, alu_src = 1; alu_op = 00, imm_src = 00. Then opcode 0100011 -> mem_write = 1, alu_src = 1, imm_src = 01, reg_write = 0, mem_read = 0.
4. Control flow: opcode 1100011 -> branch = 1, alu_op = 01, imm_src = 10, all other 1-bit outputs 0. Then opcode 1101111 -> reg_write = 1, jump = 1, imm_src = 11, alu_op = 00.
5. Illegal and hold:
   - Opcode 1111111 -> illegal_op = 1, all other outputs 0.
   - After a load decode, set en = 0, change opcode to 0100011 and clock 3 edges -> outputs keep the load values.
   - Set en = 1 -> store values appear one edge later.
6. Latency: change opcode between clock edges -> outputs unchanged until the next rising edge. Check all invariants every cycle during a random opcode sweep of 1000 cycles.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: main decoder of the single-cycle RV32I core.
// The 7-bit opcode is decoded combinationally and the result is registered,
// so there is exactly one cycle of latency from opcode to the control outputs.
// Ports:
//   clk        core clock; outputs update on the rising edge
//   rst_n      asynchronous active-low reset; clears every output
//   en         1 = load the new decode, 0 = hold the current outputs
//   opcode     instruction bits [6:0]
//   reg_write  register-file write enable
//   mem_write  data-memory write enable
//   mem_read   data-memory read enable
//   mem_to_reg writeback select (1 = memory data, 0 = ALU result)
//   alu_src    ALU operand B select (1 = immediate, 0 = rs2)
//   branch     conditional-branch instruction
//   jump       JAL instruction
//   alu_op     ALU class (00 add, 01 subtract/compare, 10 funct-decoded)
//   imm_src    immediate format (00 I, 01 S, 10 B, 11 J)
//   illegal_op opcode not in the decode table
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] opcode,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_read,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       branch,
  output logic       jump,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  logic       reg_write_c;
  logic       mem_write_c;
  logic       mem_read_c;
  logic       mem_to_reg_c;
  logic       alu_src_c;
  logic       branch_c;
  logic       jump_c;
  logic [1:0] alu_op_c;
  logic [1:0] imm_src_c;
  logic       illegal_op_c;

  // Opcode decode; unknown (including X/Z) opcodes fall to default and
  // become a NOP with only the illegal flag raised.
  always_comb begin
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_c    = 1'b0;
    branch_c     = 1'b0;
    jump_c       = 1'b0;
    alu_op_c     = ALU_ADD;
    imm_src_c    = IMM_I;
    illegal_op_c = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write_c = 1'b1;
        alu_op_c    = ALU_FUNCT;
      end
      OP_I_ALU: begin
        reg_write_c = 1'b1;
        alu_src_c   = 1'b1;
        alu_op_c    = ALU_FUNCT;
      end
      OP_LOAD: begin
        reg_write_c  = 1'b1;
        mem_read_c   = 1'b1;
        mem_to_reg_c = 1'b1;
        alu_src_c    = 1'b1;
      end
      OP_STORE: begin
        mem_write_c = 1'b1;
        alu_src_c   = 1'b1;
        imm_src_c   = IMM_S;
      end
      OP_BRANCH: begin
        branch_c  = 1'b1;
        alu_op_c  = ALU_SUB;
        imm_src_c = IMM_B;
      end
      OP_JAL: begin
        reg_write_c = 1'b1;
        jump_c      = 1'b1;
        imm_src_c   = IMM_J;
      end
      default: begin
        illegal_op_c = 1'b1;
      end
    endcase
  end

  // Output register: async clear, load on en, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_src    <= 1'b0;
      branch     <= 1'b0;
      jump       <= 1'b0;
      alu_op     <= 2'b00;
      imm_src    <= 2'b00;
      illegal_op <= 1'b0;
    end else if (en) begin
      reg_write  <= reg_write_c;
      mem_write  <= mem_write_c;
      mem_read   <= mem_read_c;
      mem_to_reg <= mem_to_reg_c;
      alu_src    <= alu_src_c;
      branch     <= branch_c;
      jump       <= jump_c;
      alu_op     <= alu_op_c;
      imm_src    <= imm_src_c;
      illegal_op <= illegal_op_c;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
// Outputs are packed as {reg_write, mem_write, mem_read, mem_to_reg, alu_src,
// branch, jump, alu_op[1:0], imm_src[1:0], illegal_op} (12 bits) for comparison.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [6:0] opcode;
  logic       reg_write;
  logic       mem_write;
  logic       mem_read;
  logic       mem_to_reg;
  logic       alu_src;
  logic       branch;
  logic       jump;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       illegal_op;

  int checks = 0;
  int errors = 0;

  // Hand-derived expected vectors, bit order as in the header.
  localparam logic [11:0] EXP_ZERO   = 12'h000;
  localparam logic [11:0] EXP_R      = 12'h810; // reg_write, alu_op=10
  localparam logic [11:0] EXP_I      = 12'h890; // reg_write, alu_src, alu_op=10
  localparam logic [11:0] EXP_LOAD   = 12'hB80; // reg_write, mem_read, mem_to_reg, alu_src
  localparam logic [11:0] EXP_STORE  = 12'h482; // mem_write, alu_src, imm_src=01
  localparam logic [11:0] EXP_BRANCH = 12'h04C; // branch, alu_op=01, imm_src=10
  localparam logic [11:0] EXP_JAL    = 12'h826; // reg_write, jump, imm_src=11
  localparam logic [11:0] EXP_ILL    = 12'h001; // illegal_op

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .opcode     (opcode),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .branch     (branch),
    .jump       (jump),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] observed();
    return {reg_write, mem_write, mem_read, mem_to_reg, alu_src,
            branch, jump, alu_op, imm_src, illegal_op};
  endfunction

  // Reference model of the decode table, used for the random sweep.
  function automatic logic [11:0] ref_decode(input logic [6:0] op);
    case (op)
      7'b0110011: return EXP_R;
      7'b0010011: return EXP_I;
      7'b0000011: return EXP_LOAD;
      7'b0100011: return EXP_STORE;
      7'b1100011: return EXP_BRANCH;
      7'b1101111: return EXP_JAL;
      default:    return EXP_ILL;
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive opcode mid-cycle, clock one edge, sample 1 time unit later.
  task automatic step(input logic [6:0] op);
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] legal_ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1101111};

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    opcode = 7'b0110011;

    // Reset held across edges with a valid opcode.
    @(posedge clk); #1;
    check("reset_hold_1", EXP_ZERO);
    @(posedge clk); #1;
    check("reset_hold_2", EXP_ZERO);
    @(negedge clk);
    rst_n = 1'b1;

    // First decode after release.
    step(7'b0110011);
    check("r_type", EXP_R);

    // Async reset mid-cycle clears before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", EXP_ZERO);
    @(negedge clk);
    rst_n = 1'b1;

    step(7'b0110011);
    check("r_type_after_reset", EXP_R);
    step(7'b0010011);
    check("i_alu", EXP_I);
    step(7'b0000011);
    check("load", EXP_LOAD);
    step(7'b0100011);
    check("store", EXP_STORE);
    step(7'b1100011);
    check("branch", EXP_BRANCH);
    step(7'b1101111);
    check("jal", EXP_JAL);
    step(7'b1111111);
    check("illegal_7f", EXP_ILL);
    step(7'b0000000);
    check("illegal_00", EXP_ILL);
    step(7'b0110111);
    check("illegal_lui", EXP_ILL);

    // Hold: load decoded, then en low with store opcode for 3 edges.
    step(7'b0000011);
    check("hold_load", EXP_LOAD);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(7'b0100011);
      check($sformatf("hold_edge_%0d", i), EXP_LOAD);
    end
    en = 1'b1;
    step(7'b0100011);
    check("release_hold_store", EXP_STORE);

    // Reset forces zero even with en low; first decode needs en high.
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_en_low", EXP_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    step(7'b1100011);
    check("post_reset_en_low", EXP_ZERO);
    en = 1'b1;
    step(7'b1100011);
    check("post_reset_en_high", EXP_BRANCH);

    // Latency: opcode change between edges leaves outputs alone until the edge.
    #2;
    opcode = 7'b1101111;
    #1;
    check("latency_before_edge", EXP_BRANCH);
    @(posedge clk); #1;
    check("latency_after_edge", EXP_JAL);

    // Random sweep: model compare plus invariants every cycle.
    for (int i = 0; i < 1000; i++) begin
      logic [6:0] op;
      if ($urandom_range(1, 0) == 1)
        op = legal_ops[$urandom_range(5, 0)];
      else
        op = 7'($urandom);
      en = ($urandom_range(7, 0) != 0);
      if (en) begin
        step(op);
        check($sformatf("sweep_%0d_op_%07b", i, op), ref_decode(op));
      end else begin
        step(op);
      end
      check_bit("inv_rd_wr_exclusive", mem_read & mem_write, 1'b0);
      check_bit("inv_m2r_implies_rd", mem_to_reg & ~mem_read, 1'b0);
      check_bit("inv_onehot_br_j_mw",
                (32'(branch) + 32'(jump) + 32'(mem_write)) <= 32'd1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
